// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage memory access unit: memory op codes,
// bus transfer sizes, FSM state codes and small request-decode helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } accStateT;

  // Unknown op codes fall through to a word access.
  function automatic logic [1:0] opSize(input logic [2:0] op);
    logic [1:0] size;
    case (op)
      MEMOP_B, MEMOP_BU: size = SIZE_BYTE;
      MEMOP_H, MEMOP_HU: size = SIZE_HALF;
      default:           size = SIZE_WORD;
    endcase
    return size;
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return ((size == SIZE_HALF) && addrLo[0]) ||
           ((size == SIZE_WORD) && (addrLo != 2'b00));
  endfunction

  function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wd[7:0]}};
      SIZE_HALF: lanes = {2{wd[15:0]}};
      default:   lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load aligner: picks the addressed byte/half lane out of a bus word and
// sign- or zero-extends it according to the load op.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  op,
  output logic [31:0] aligned
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = rdata[{addrLo, 3'b000} +: 8];
    laneHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEMOP_B:  aligned = {{24{laneByte[7]}}, laneByte};
      MEMOP_BU: aligned = {24'd0, laneByte};
      MEMOP_H:  aligned = {{16{laneHalf[15]}}, laneHalf};
      MEMOP_HU: aligned = {16'd0, laneHalf};
      default:  aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: issues one bus transaction per aligned load/store
// and stalls the pipeline until the response lands in the capture register.
//
// state | meaning
// IDLE  | no access in flight; aligned request launches on the next edge
// ADDR  | data_req high, waiting for data_addr_ok
// DATA  | address accepted, waiting for data_data_ok
// DONE  | access complete; held here while stallW keeps the instruction in M
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [2:0]  memopM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  input  logic        stallW,
  output logic [31:0] readdataM,
  output logic        stall_memM,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  accStateT    state, nextState;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqWr;
  logic [31:0] reqWdata;
  logic [2:0]  reqOp;
  logic [31:0] captureData;
  logic [31:0] alignedData;

  logic [1:0]  curSize;
  logic        misaligned;
  logic        reqValid;
  logic        respArrives;

  assign curSize    = opSize(memopM);
  assign misaligned = isMisaligned(curSize, addrM[1:0]);
  assign reqValid   = memenM && !misaligned;

  assign adelM = rst && memenM && !memwriteM && misaligned;
  assign adesM = rst && memenM &&  memwriteM && misaligned;

  // Responses are only meaningful while the access is outstanding.
  assign respArrives = data_data_ok &&
                       (((state == ST_ADDR) && data_addr_ok) || (state == ST_DATA));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    stall_memM = 1'b0;
    data_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_memM = reqValid;
        if (reqValid) nextState = ST_ADDR;
      end
      ST_ADDR: begin
        stall_memM = 1'b1;
        data_req   = 1'b1;
        if (data_addr_ok) nextState = data_data_ok ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        stall_memM = 1'b1;
        if (data_data_ok) nextState = ST_DONE;
      end
      ST_DONE: begin
        if (!stallW) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqAddr  <= 32'd0;
      reqSize  <= SIZE_BYTE;
      reqWr    <= 1'b0;
      reqWdata <= 32'd0;
      reqOp    <= MEMOP_B;
    end else if ((state == ST_IDLE) && reqValid) begin
      reqAddr  <= addrM;
      reqSize  <= curSize;
      reqWr    <= memwriteM;
      reqWdata <= storeLanes(curSize, writedataM);
      reqOp    <= memopM;
    end
  end

  load_align uLoadAlign (
    .rdata   (data_rdata),
    .addrLo  (reqAddr[1:0]),
    .op      (reqOp),
    .aligned (alignedData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captureData <= 32'd0;
    end else if (respArrives && !reqWr) begin
      captureData <= alignedData;
    end
  end

  assign readdataM  = captureData;
  assign data_wr    = reqWr;
  assign data_size  = reqSize;
  assign data_addr  = reqAddr;
  assign data_wdata = reqWdata;

endmodule
